// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if
//   Bundle between the requesters and the register write arbiter.
//   master : requester side (drives req/req_clr/req_data, sees grant/ack)
//   slave  : arbiter side (samples requests, drives grant/ack and the
//            register-facing load/I/reg_clear strobes plus busy)
interface reg_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       req_clr;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       grant;
    logic                   ack;
    logic                   load;
    logic [WIDTH-1:0]       I;
    logic                   reg_clear;
    logic                   busy;

    modport master (
        output req, req_clr, req_data,
        input  grant, ack, load, I, reg_clear, busy
    );

    modport slave (
        input  req, req_clr, req_data,
        output grant, ack, load, I, reg_clear, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Shares one WIDTH-bit load/clear register between N_REQ requesters.
//   One winner per transaction; every transaction is IDLE -> WRITE -> ACK,
//   so the register sees a single-cycle load or clear strobe and the winner
//   gets a one-cycle ack while the register already holds the new value.
//
//   Ports:
//     clk    rising-edge clock (shared with the register)
//     clear  synchronous active-high controller reset
//     bus    reg_write_arbiter_if.slave: req/req_clr/req_data in,
//            grant/ack/load/I/reg_clear/busy out (all registered)
//
//   Build option: REG_ARB_FIXED_PRIO_EN
//     defined   -> fixed priority, lowest requesting index wins
//     undefined -> round-robin starting at a rotating pointer (default)
module reg_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               clear,
    reg_write_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

    state_t           state;
    logic [N_REQ-1:0] grant_q;
    logic             ack_q;
    logic             load_q;
    logic [WIDTH-1:0] i_q;
    logic             reg_clear_q;
    logic             busy_q;

    logic             win_vld;
    logic [IW-1:0]    win_idx;
    int               k;

`ifdef REG_ARB_FIXED_PRIO_EN
    // Lowest set index wins; no rotation state.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        k       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = i;
            if (!win_vld && bus.req[k]) begin
                win_vld = 1'b1;
                win_idx = IW'(k);
            end
        end
    end
`else
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;

    // Search p, p+1, ... wrapping at N_REQ; first set request wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        k       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (!win_vld && bus.req[k]) begin
                win_vld = 1'b1;
                win_idx = IW'(k);
            end
        end
    end

    assign ptr_nxt = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (clear)
            ptr <= '0;
        else if (state == IDLE && win_vld)
            ptr <= ptr_nxt;
    end
`endif

    // Op and data are captured straight into the output registers at
    // arbitration, so later requester activity cannot disturb the strobe.
    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= IDLE;
            grant_q     <= '0;
            ack_q       <= 1'b0;
            load_q      <= 1'b0;
            i_q         <= '0;
            reg_clear_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state       <= WRITE;
                        busy_q      <= 1'b1;
                        grant_q     <= N_REQ'(1) << win_idx;
                        reg_clear_q <= bus.req_clr[win_idx];
                        load_q      <= !bus.req_clr[win_idx];
                        i_q         <= bus.req_clr[win_idx] ? '0
                                     : bus.req_data[int'(win_idx)*WIDTH +: WIDTH];
                    end
                end
                WRITE: begin
                    state       <= ACK;
                    load_q      <= 1'b0;
                    reg_clear_q <= 1'b0;
                    i_q         <= '0;
                    ack_q       <= 1'b1;
                end
                ACK: begin
                    state   <= IDLE;
                    ack_q   <= 1'b0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    grant_q     <= '0;
                    ack_q       <= 1'b0;
                    load_q      <= 1'b0;
                    i_q         <= '0;
                    reg_clear_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.load      = load_q;
    assign bus.I         = i_q;
    assign bus.reg_clear = reg_clear_q;
    assign bus.busy      = busy_q;

endmodule
